// File: rtl/sram_controller.sv
// sram_controller: stalls the memory stage while one 32-bit word moves as two 16-bit SRAM
// half-accesses (low half, then high half), each held for ACCESS_CYCLES cycles.
// Ports: clk, rst (async, active-low), wr_en/rd_en/address/write_data in, read_data/ready out,
// SRAM_DQ (inout), SRAM_ADDR and active-low SRAM_WE_N/OE_N/CE_N/UB_N/LB_N strobes.
// Macro SRAM_RDBUF_EN adds a one-entry read buffer that answers repeat reads without a stall.
module sram_controller #(
  parameter int unsigned ACCESS_CYCLES = 3,
  parameter logic [31:0] DATA_BASE     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        op_wr;
  logic [16:0] widx;
  logic [31:0] wdata;
  logic [15:0] lo_q;
  logic [31:0] rdata_q;

  logic        req, start, hit, act, last;
  logic [31:0] off;
  logic [16:0] idx;
  logic        unused_off;

  assign req        = wr_en | rd_en;
  assign off        = address - DATA_BASE;
  assign idx        = off[18:2];
  assign unused_off = ^{off[31:19], off[1:0]};
  assign last       = (cnt == LAST);
  assign act        = (state == LOW) || (state == HIGH);

`ifdef SRAM_RDBUF_EN
  logic        buf_vld;
  logic [16:0] buf_idx;
  logic [31:0] buf_data;

  // a hit is a pure read; a write always goes to the SRAM
  assign hit = (state == IDLE) & rd_en & ~wr_en
             & buf_vld & (buf_idx == idx);
  assign read_data = hit ? buf_data : rdata_q;
`else
  assign hit = 1'b0;
  assign read_data = rdata_q;
`endif

  assign start = (state == IDLE) & req & ~hit;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~req | hit;
        if (start) begin
          state_nx = LOW;
          cnt_nx   = 4'd0;
        end
      end
      LOW: begin
        if (last) begin
          state_nx = HIGH;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign SRAM_CE_N = ~act;
  assign SRAM_UB_N = ~act;
  assign SRAM_LB_N = ~act;
  assign SRAM_WE_N = ~(act & op_wr);
  assign SRAM_OE_N = ~(act & ~op_wr);
  assign SRAM_ADDR = act ? {widx, state == HIGH} : 18'd0;
  assign SRAM_DQ   = (act & op_wr)
                   ? ((state == HIGH) ? wdata[31:16] : wdata[15:0])
                   : 16'hzzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      op_wr   <= 1'b0;
      widx    <= 17'd0;
      wdata   <= 32'd0;
      lo_q    <= 16'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start) begin
        op_wr <= wr_en;
        widx  <= idx;
        wdata <= write_data;
      end
      if (state == LOW && last && !op_wr)
        lo_q <= SRAM_DQ;
      // read_data changes only once the whole word is in
      if (state == HIGH && last && !op_wr)
        rdata_q <= {SRAM_DQ, lo_q};
`ifdef SRAM_RDBUF_EN
      if (hit)
        rdata_q <= buf_data;
`endif
    end
  end

`ifdef SRAM_RDBUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld  <= 1'b0;
      buf_idx  <= 17'd0;
      buf_data <= 32'd0;
    end else begin
      if (state == HIGH && last && !op_wr) begin
        buf_vld  <= 1'b1;
        buf_idx  <= widx;
        buf_data <= {SRAM_DQ, lo_q};
      end
      if (start && wr_en && buf_vld && buf_idx == idx)
        buf_data <= write_data;
    end
  end
`endif

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ACCESS_CYCLES, default 3, SHALL set the cycles each 16-bit SRAM half-access is held (legal range 1..15).
REQ-002 Parameter DATA_BASE, default 1024, SHALL be the byte address subtracted from the request address before mapping.
REQ-003 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  memory-stage write request.
REQ-006 rd_en  input  1  memory-stage read request.
REQ-007 address  input  32  byte address from the memory stage.
REQ-008 write_data  input  32  word to store.
REQ-009 read_data  output  32  word returned for a read.
REQ-010 ready  output  1  high = no access in flight; low = freeze the pipeline.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM strobes.

Function
REQ-014 The FSM SHALL have states IDLE, LOW, HIGH and DONE.
REQ-015 In IDLE with wr_en or rd_en high at a rising edge, the FSM SHALL latch address, write_data and the operation type, then enter LOW.
REQ-016 LOW and HIGH SHALL each last exactly ACCESS_CYCLES cycles, counted by an internal counter; HIGH then SHALL go to DONE, and DONE SHALL go to IDLE after one cycle.
REQ-017 ready SHALL be combinational: 0 in IDLE while a request is asserted, 0 in LOW and HIGH, 1 in DONE, 1 in IDLE with no request.
REQ-018 Total stall SHALL be 1+2*ACCESS_CYCLES cycles of ready=0 per access (7 at the default).
REQ-019 Word index w SHALL be (latched address - DATA_BASE)>>2, truncated mod 2^17; SRAM_ADDR SHALL be {w[16:0],0} in LOW and {w[16:0],1} in HIGH.
REQ-020 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be 0 in LOW and HIGH and 1 otherwise.
REQ-021 Write: SRAM_WE_N SHALL be 0 in LOW and HIGH; SRAM_DQ SHALL carry write_data[15:0] in LOW and write_data[31:16] in HIGH, and SHALL be high-Z in every other state.
REQ-022 Read: SRAM_OE_N SHALL be 0 in LOW and HIGH; SRAM_DQ SHALL be sampled on the last cycle of LOW into read_data[15:0] and on the last cycle of HIGH into read_data[31:16].
REQ-023 read_data SHALL hold its value until the next read completes.
REQ-024 wr_en and rd_en high together SHALL perform the write only.
REQ-025 Request changes after the IDLE sample SHALL be ignored until the FSM returns to IDLE.
REQ-026 A request still held in DONE SHALL NOT start a new access; it is re-sampled only from IDLE.

Reset
REQ-027 rst low SHALL force, immediately: state IDLE, counter 0, read_data 0, every strobe 1, SRAM_ADDR 0, SRAM_DQ high-Z, ready 1 (or 0 while a request is present).
REQ-028 Reset during LOW or HIGH SHALL abort the access with no further SRAM strobe activity.

Configuration
REQ-029 Macro SRAM_RDBUF_EN SHALL, when defined, add a one-entry read buffer holding a valid flag, word index and data.
REQ-030 With SRAM_RDBUF_EN, a read in IDLE whose index matches a valid entry SHALL keep ready=1, drive read_data from the buffer in the same cycle and issue no SRAM strobes.
REQ-031 With SRAM_RDBUF_EN, every completed read SHALL fill the buffer; a write to the buffered index SHALL update the buffer data; reset SHALL clear the valid flag.
REQ-032 Without SRAM_RDBUF_EN, every read SHALL access the SRAM as in REQ-015 to REQ-022.

Verification
REQ-033 Write 0xDEADBEEF to address 1028 -> SRAM_ADDR 2 then 3, SRAM_DQ carries 0xBEEF then 0xDEAD, ready low 7 cycles.
REQ-034 Read 1028 with SRAM model returning 0xBEEF/0xDEAD -> read_data=0xDEADBEEF in DONE, ready high in the 8th cycle.
REQ-035 wr_en=rd_en=1 at 1024 with write_data 0x12345678 -> WE_N low, OE_N high, SRAM words 0/1 = 0x5678/0x1234.
REQ-036 rst low during the second LOW cycle -> strobes 1 and DQ high-Z in the same cycle, state IDLE, no HIGH phase.
REQ-037 With SRAM_RDBUF_EN, read 1028 twice -> second read has ready=1, zero SRAM strobes and the same data; repeat without the macro -> 7-cycle stall.
